// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: queue geometry and
// the default layout of one prefetch-queue entry.
package fetch_pkg;

   localparam int FETCH_QDEPTH = 2;
   localparam int FETCH_CNT_W  = 2;

   // Default entry widths; the top re-declares the entry with its own widths
   localparam int FETCH_DWIDTH = 16;
   localparam int FETCH_AWIDTH = 8;

   typedef struct packed {
      logic [FETCH_DWIDTH-1:0] data;
      logic [FETCH_AWIDTH-1:0] pc;
   } fetch_entry_t;

   // True when the queue can take another entry without a pop
   function automatic logic fetch_has_room(input logic [FETCH_CNT_W-1:0] cnt);
      return cnt < FETCH_CNT_W'(FETCH_QDEPTH);
   endfunction

endpackage

// File: rtl/fetch_q.sv
// Two-entry synchronous prefetch FIFO. flush beats push and pop; the head
// register keeps its last value when the queue drains or is flushed.
module fetch_q
   import fetch_pkg::*;
#(
   parameter type entry_t = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  entry_t                 din,
   output logic [FETCH_CNT_W-1:0] count,
   output entry_t                 head
);

   entry_t slot0;
   entry_t slot1;
   logic   pop_ok;
   logic   push_ok;

   // Qualify requests so the queue can never underflow or overflow
   always_comb begin
      pop_ok  = pop && (count != '0);
      push_ok = push && (fetch_has_room(count) || pop_ok);
   end

   // Storage and occupancy; slot0 is always the head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else begin
         unique case ({push_ok, pop_ok})
            2'b11: begin
               if (count == FETCH_CNT_W'(FETCH_QDEPTH)) begin
                  slot0 <= slot1;
                  slot1 <= din;
               end else begin
                  slot0 <= din;
               end
            end
            2'b10: begin
               if (count == '0) slot0 <= din;
               else             slot1 <= din;
               count <= count + FETCH_CNT_W'(1);
            end
            2'b01: begin
               if (count == FETCH_CNT_W'(FETCH_QDEPTH)) slot0 <= slot1;
               count <= count - FETCH_CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign head = slot0;

endmodule

// File: rtl/rom_fetch.sv
// Instruction fetch stage in front of a combinational-read ROM: PC, enqueue /
// dequeue control, branch redirect and a 2-entry prefetch queue.
// Optional feature macro: ROM_FETCH_STALL_CNT_EN adds a saturating stall_cnt.
module rom_fetch
   import fetch_pkg::*;
#(
   parameter int                DWIDTH   = 16,
   parameter int                AWIDTH   = 8,
   parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [AWIDTH-1:0] rom_addr,
   input  logic [DWIDTH-1:0] rom_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DWIDTH-1:0] inst_data,
   output logic [AWIDTH-1:0] inst_pc,
   input  logic              br_valid,
   input  logic [AWIDTH-1:0] br_target
`ifdef ROM_FETCH_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   typedef struct packed {
      logic [DWIDTH-1:0] data;
      logic [AWIDTH-1:0] pc;
   } entry_t;

   logic [AWIDTH-1:0]      pc;
   logic [FETCH_CNT_W-1:0] count;
   logic                   deq;
   logic                   enq;
   entry_t                 tail_entry;
   entry_t                 head;

   assign rom_addr   = pc;
   assign inst_valid = (count != '0);
   assign deq        = inst_valid & inst_ready;
   assign enq        = !br_valid & (fetch_has_room(count) | deq);
   assign tail_entry = '{data: rom_data, pc: pc};
   assign inst_data  = head.data;
   assign inst_pc    = head.pc;

   // Program counter: a redirect reloads it, every enqueue advances it (wraps)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        pc <= RESET_PC;
      else if (br_valid) pc <= br_target;
      else if (enq)      pc <= pc + AWIDTH'(1);
   end

   fetch_q #(
      .entry_t (entry_t)
   ) u_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (enq),
      .pop   (deq & !br_valid),
      .flush (br_valid),
      .din   (tail_entry),
      .count (count),
      .head  (head)
   );

`ifdef ROM_FETCH_STALL_CNT_EN
   // Count cycles where the decoder holds off a valid word; saturates, reset-only clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       stall_cnt <= '0;
      else if (inst_valid && !inst_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_rom_fetch.sv
// Self-checking bench for rom_fetch: queue-based reference model checked every
// cycle, plus directed cases with literal expected values, then random traffic.
module tb_rom_fetch;

   localparam logic [7:0] RPC = 8'h10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inst_ready = 1'b0;
   logic        br_valid = 1'b0;
   logic [7:0]  br_target = 8'h00;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data;
   logic        inst_valid;
   logic [15:0] inst_data;
   logic [7:0]  inst_pc;
`ifdef ROM_FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int failures = 0;

   // ROM contents: each word is its address XOR A5A5
   assign rom_data = {8'h00, rom_addr} ^ 16'hA5A5;

   always #5 clk = ~clk;

   rom_fetch #(
      .DWIDTH   (16),
      .AWIDTH   (8),
      .RESET_PC (RPC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst_data  (inst_data),
      .inst_pc    (inst_pc),
      .br_valid   (br_valid),
      .br_target  (br_target)
`ifdef ROM_FETCH_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   // Reference model: a queue of fetched words plus a program counter
   typedef struct {
      logic [15:0] d;
      logic [7:0]  p;
   } ent_t;

   ent_t        mq[$];
   logic [7:0]  mpc = RPC;
   ent_t        mlast = '{16'h0000, 8'h00};
   int          mstall = 0;

   always @(posedge clk or negedge rst_n) begin
      int  sz;
      bit  mdeq;
      bit  menq;
      if (!rst_n) begin
         mq.delete();
         mpc    = RPC;
         mlast  = '{16'h0000, 8'h00};
         mstall = 0;
      end else begin
         sz   = mq.size();
         mdeq = (sz > 0) && inst_ready;
         if (sz > 0 && !inst_ready && mstall < 65535) mstall++;
         if (br_valid) begin
            mq.delete();
            mpc = br_target;
         end else begin
            menq = (sz < 2) || mdeq;
            if (mdeq) void'(mq.pop_front());
            if (menq) begin
               mq.push_back('{{8'h00, mpc} ^ 16'hA5A5, mpc});
               mpc = mpc + 8'd1;
            end
         end
         if (mq.size() > 0) mlast = mq[0];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model on every falling edge
   always @(negedge clk) begin
      checkOutput("m_rom_addr",   32'(rom_addr),   32'(mpc));
      checkOutput("m_inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
      checkOutput("m_inst_data",  32'(inst_data),  32'(mlast.d));
      checkOutput("m_inst_pc",    32'(inst_pc),    32'(mlast.p));
      checkOutput("count_not_3",  32'(dut.count == 2'd3), 32'd0);
`ifdef ROM_FETCH_STALL_CNT_EN
      checkOutput("m_stall_cnt",  32'(stall_cnt),  32'(mstall));
`endif
   end

   // Drive inputs just after an edge, then advance to just after the next edge
   task automatic applyStimulus(input logic rdy, input logic bv, input logic [7:0] bt);
      inst_ready = rdy;
      br_valid   = bv;
      br_target  = bt;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset values
      inst_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_valid", 32'(inst_valid), 32'd0);
      checkOutput("rst_addr",  32'(rom_addr),   32'h10);
      checkOutput("rst_data",  32'(inst_data),  32'h0);
      checkOutput("rst_pc",    32'(inst_pc),    32'h0);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_valid_pre_edge", 32'(inst_valid), 32'd0);

      // Streaming from RESET_PC
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("s0_valid", 32'(inst_valid), 32'd1);
      checkOutput("s0_pc",    32'(inst_pc),    32'h10);
      checkOutput("s0_data",  32'(inst_data),  32'hA5B5);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("s1_pc",    32'(inst_pc),    32'h11);
      checkOutput("s1_data",  32'(inst_data),  32'hA5B4);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("s2_pc",    32'(inst_pc),    32'h12);
      checkOutput("s2_data",  32'(inst_data),  32'hA5B7);

      // Backpressure from reset
      doReset();
      repeat (5) applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("bp_addr",  32'(rom_addr),   32'h12);
      checkOutput("bp_pc",    32'(inst_pc),    32'h10);
      checkOutput("bp_valid", 32'(inst_valid), 32'd1);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("bp_next_pc", 32'(inst_pc),  32'h11);
      repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);

      // PC wrap
      applyStimulus(1'b1, 1'b1, 8'hFE);
      checkOutput("wr_valid0", 32'(inst_valid), 32'd0);
      checkOutput("wr_addr0",  32'(rom_addr),   32'hFE);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("wr_pc_fe",  32'(inst_pc),    32'hFE);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("wr_pc_ff",  32'(inst_pc),    32'hFF);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("wr_pc_00",  32'(inst_pc),    32'h00);
      checkOutput("wr_data_00", 32'(inst_data), 32'hA5A5);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("wr_pc_01",  32'(inst_pc),    32'h01);
      checkOutput("wr_valid1", 32'(inst_valid), 32'd1);

      // Redirect while full and ready
      repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("br_full", 32'(dut.count), 32'd2);
      applyStimulus(1'b1, 1'b1, 8'h40);
      checkOutput("br_valid0", 32'(inst_valid), 32'd0);
      checkOutput("br_addr",   32'(rom_addr),   32'h40);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("br_valid1", 32'(inst_valid), 32'd1);
      checkOutput("br_pc",     32'(inst_pc),    32'h40);
      checkOutput("br_data",   32'(inst_data),  32'hA5E5);

      // Asynchronous reset between edges
      repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_valid", 32'(inst_valid), 32'd0);
      checkOutput("ar_addr",  32'(rom_addr),   32'h10);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("ar_restart_pc", 32'(inst_pc), 32'h10);

`ifdef ROM_FETCH_STALL_CNT_EN
      // Stall counting and redirect independence
      doReset();
      repeat (8) applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("st_cnt7", 32'(stall_cnt), 32'd7);
      applyStimulus(1'b1, 1'b1, 8'h20);
      checkOutput("st_after_br", 32'(stall_cnt), 32'd7);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("st_hold", 32'(stall_cnt), 32'd7);
`endif

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 8'($urandom));
      end
      applyStimulus(1'b1, 1'b0, 8'h00);

      @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rom_fetch.md
Name: rom_fetch

Overview:
- Instruction fetch stage sitting directly in front of the combinational-read program ROM.
- Drives the ROM address from an internal program counter and captures the returned word into a 2-entry prefetch queue.
- Presents words to the downstream decoder over a valid/ready handshake, tagged with their fetch address.
- Accepts branch redirects that flush the queue and reload the program counter.

Parameters:
- DWIDTH, 16, instruction word width; must match the ROM DWIDTH.
- AWIDTH, 8, ROM address width; PC width.
- RESET_PC, 0, PC value loaded on reset (AWIDTH bits).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- rom_addr  out  AWIDTH  address to ROM; equals the PC register, driven combinationally from it.
- rom_data  in  DWIDTH  ROM word for rom_addr, valid in the same cycle.
- inst_valid  out  1  queue head holds a word.
- inst_ready  in  1  decoder accepts the head this cycle.
- inst_data  out  DWIDTH  head word.
- inst_pc  out  AWIDTH  address the head word was fetched from.
- br_valid  in  1  redirect request, single-cycle pulse.
- br_target  in  AWIDTH  redirect address.

Behaviour:
- Reset (rst_n low, asynchronous):
  - PC = RESET_PC, so rom_addr = RESET_PC.
  - Queue empty, inst_valid = 0.
  - inst_data = 0, inst_pc = 0.
- Definitions:
  - deq = inst_valid & inst_ready.
  - enq = !br_valid & (count < 2 | deq).
- Queue update:
  - On enq, the entry {rom_data, PC} is written at the tail and PC <= PC + 1, wrapping modulo 2^AWIDTH (2^AWIDTH-1 -> 0, no flag).
  - On deq, the head is popped.
  - Simultaneous enq and deq on a full queue is legal; count stays 2.
- Latency:
  - The word at PC is visible on inst_data the cycle after the edge that enqueued it.
  - After reset release, inst_valid rises after the first clk edge.
  - Sustained throughput is 1 word/cycle with inst_ready held high.
- Backpressure:
  - count == 2 and !deq: PC holds and no enqueue occurs.
  - inst_data and inst_pc stay stable while inst_valid & !inst_ready.
- Redirect (br_valid high):
  - Redirect wins over enq and deq in the same cycle.
  - At the edge, the queue is cleared (count = 0) and PC <= br_target.
  - inst_valid = 0 in the following cycle.
  - The first word from the target appears one cycle after that.
  - A deq handshake coinciding with br_valid is treated by the decoder as consumed; this block discards it with the flush.
- Back-to-back redirects: each loads PC and flushes; the last one wins.
- Empty output values: when the queue is empty, inst_data and inst_pc retain their last values. Only inst_valid is meaningful.
- Reset asserted mid-operation: all state returns to reset values immediately, without a clock edge.
- Count encoding: 0..2, held in a 2-bit register. Value 3 is unreachable; a bench asserts this.

Optional Feature:
- Macro: ROM_FETCH_STALL_CNT_EN.
- When defined:
  - Extra output port stall_cnt, out, 16 bits.
  - Increments on every cycle with inst_valid & !inst_ready, saturating at 16'hFFFF.
  - Cleared by reset only; unaffected by redirects.
- When undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - FETCH_QDEPTH = 2 and FETCH_CNT_W = 2.
  - Typedef fetch_entry_t {data[DWIDTH], pc[AWIDTH]}; widths are supplied as package parameters defaulting to 16/8.
- Sub-module fetch_q: 2-entry synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - flush has priority over push and pop.
- Top level holds the PC, enq/deq logic and the optional stall counter.

Test Plan:
- Reset release with RESET_PC=8'h10, ROM word at addr = addr XOR 16'hA5A5, inst_ready=1 -> inst_valid high after first edge; inst_pc sequence 10,11,12 with data A5B5,A5B4,A5B7, one per cycle.
- inst_ready=0 for 5 cycles from reset -> queue fills to 2, rom_addr freezes at RESET_PC+2, inst_pc holds RESET_PC; on inst_ready=1, words are delivered in order with no loss or duplication.
- PC at 8'hFE, free-running -> inst_pc FE, FF, 00, 01; no stall at wrap.
- br_valid pulse, br_target=8'h40, while queue is full and inst_ready=1 -> next cycle inst_valid=0 and rom_addr=40; following cycle inst_pc=40; old entries are never presented.
- Async reset asserted mid-stream, between edges -> inst_valid=0 and rom_addr=RESET_PC immediately; the stream restarts from RESET_PC after release.
- With ROM_FETCH_STALL_CNT_EN defined, inst_ready=0 for 7 cycles with inst_valid high -> stall_cnt=7; a redirect leaves stall_cnt unchanged.
